// File: rtl/prog_loader_pkg.sv
// Shared encodings for the program loader: FSM states, frame sync byte, error codes.
package prog_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_L,
    ST_LEN_H,
    ST_DATA_L,
    ST_DATA_H,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } load_state_t;

  localparam logic [7:0] LOAD_SYNC_BYTE = 8'hA5;

  localparam logic [1:0] LOAD_ERR_NONE    = 2'd0;
  localparam logic [1:0] LOAD_ERR_LEN     = 2'd1;
  localparam logic [1:0] LOAD_ERR_CSUM    = 2'd2;
  localparam logic [1:0] LOAD_ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/prog_loader_timer.sv
// Idle-cycle counter: counts enabled cycles since the last clear, flags expiry at TIMEOUT_CYC.
module loader_timer #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT_CYC));

  // Saturates at the limit so a stalled owner never sees the flag drop by wrap-around.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames A5/LEN/payload/XOR-checksum into instruction memory
// writes from address 0, and releases the CPU only after a load with a matching checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          CPU_WIDTH   = 16,
  parameter int          ADDR_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [CPU_WIDTH-1:0]  imem_wdata,
  output logic                  cpu_en,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);

  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  load_state_t state, state_nxt;

  logic                  active;
  logic                  accept;
  logic                  start_ok;
  logic                  expired;
  logic                  len_bad;
  logic                  last_word;
  logic [16:0]           n_word;
  logic [7:0]            len_l;
  logic [15:0]           len;
  logic [7:0]            lo_q;
  logic [7:0]            csum;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            err_q, err_nxt;

  assign active = (state == ST_SYNC)   || (state == ST_LEN_L)  || (state == ST_LEN_H) ||
                  (state == ST_DATA_L) || (state == ST_DATA_H) || (state == ST_CSUM);

  // Stop accepting once expired so a late byte cannot race the abort.
  assign rx_ready  = active && !expired;
  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && !active;
  assign n_word    = {1'b0, rx_data, len_l};
  assign len_bad   = (n_word == 17'd0) || (n_word > CAP);
  assign last_word = (17'(idx) + 17'd1) == {1'b0, len};

  assign busy   = active;
  assign done   = (state == ST_DONE);
  assign cpu_en = (state == ST_DONE);
  assign err    = err_q;

  loader_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept || start_ok),
    .en     (active),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    if (start_ok) begin
      state_nxt = ST_SYNC;
      err_nxt   = LOAD_ERR_NONE;
    end else if (active && expired) begin
      state_nxt = ST_ERR;
      err_nxt   = LOAD_ERR_TIMEOUT;
    end else if (accept) begin
      case (state)
        ST_SYNC: begin
          if (rx_data == LOAD_SYNC_BYTE) state_nxt = ST_LEN_L;
        end
        ST_LEN_L: state_nxt = ST_LEN_H;
        ST_LEN_H: begin
          if (len_bad) begin
            state_nxt = ST_ERR;
            err_nxt   = LOAD_ERR_LEN;
          end else begin
            state_nxt = ST_DATA_L;
          end
        end
        ST_DATA_L: state_nxt = ST_DATA_H;
        ST_DATA_H: state_nxt = last_word ? ST_CSUM : ST_DATA_L;
        ST_CSUM: begin
          if (rx_data == csum) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ERR;
            err_nxt   = LOAD_ERR_CSUM;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err_q      <= LOAD_ERR_NONE;
      len_l      <= 8'd0;
      len        <= 16'd0;
      lo_q       <= 8'd0;
      csum       <= 8'd0;
      idx        <= '0;
    end else begin
      imem_we <= 1'b0;
      err_q   <= err_nxt;
      if (start_ok) begin
        idx  <= '0;
        csum <= 8'd0;
      end else if (accept) begin
        case (state)
          ST_LEN_L: len_l <= rx_data;
          ST_LEN_H: len   <= {rx_data, len_l};
          ST_DATA_L: begin
            lo_q <= rx_data;
            csum <= csum ^ rx_data;
          end
          ST_DATA_H: begin
            imem_we    <= 1'b1;
            imem_addr  <= idx;
            imem_wdata <= CPU_WIDTH'({rx_data, lo_q});
            idx        <= idx + 1'b1;
            csum       <= csum ^ rx_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a short timeout so the stall case stays cheap.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_en;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;

  int          wr_cnt = 0;
  logic [7:0]  wr_addr [64];
  logic [15:0] wr_data [64];
  int          base;

  always #5 clk = ~clk;

  prog_loader #(
    .CPU_WIDTH  (16),
    .ADDR_WIDTH (8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_en    (cpu_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Every cycle with imem_we high is logged, so a stretched pulse shows up as an extra write.
  always @(negedge clk) begin
    if (imem_we && wr_cnt < 64) begin
      wr_addr[wr_cnt] = imem_addr;
      wr_data[wr_cnt] = imem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    rx_data  = b;
    rx_valid = 1'b1;
    w = 0;
    while (!rx_ready && w < 40) begin
      tick();
      w++;
    end
    chk("rdy_wait", {31'd0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_imem_we",  {31'd0, imem_we},  32'd0);
    chk("rst_addr",     {24'd0, imem_addr}, 32'd0);
    chk("rst_wdata",    {16'd0, imem_wdata}, 32'd0);
    chk("rst_cpu_en",   {31'd0, cpu_en}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_done",     {31'd0, done}, 32'd0);
    chk("rst_err",      {30'd0, err}, 32'd0);
    chk("rst_no_write", wr_cnt, 32'd0);
    rx_valid = 1'b0;

    // Good two-word load, with a stray start pulse mid-frame.
    base = wr_cnt;
    pulse_start();
    chk("s2_busy", {31'd0, busy}, 32'd1);
    chk("s2_ready", {31'd0, rx_ready}, 32'd1);
    send_byte(8'hA5);
    send_byte(8'h02);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h22);
    send_byte(8'h11);
    send_byte(8'h32);
    chk("s2_done",   {31'd0, done}, 32'd1);
    chk("s2_cpu_en", {31'd0, cpu_en}, 32'd1);
    chk("s2_busy_lo", {31'd0, busy}, 32'd0);
    chk("s2_err",    {30'd0, err}, 32'd0);
    chk("s2_ready_lo", {31'd0, rx_ready}, 32'd0);
    tick();
    chk("s2_nwr",  wr_cnt - base, 32'd2);
    chk("s2_a0",   {24'd0, wr_addr[base]}, 32'd0);
    chk("s2_d0",   {16'd0, wr_data[base]}, 32'h0001);
    chk("s2_a1",   {24'd0, wr_addr[base+1]}, 32'd1);
    chk("s2_d1",   {16'd0, wr_data[base+1]}, 32'h1122);
    chk("s2_addr_hold", {24'd0, imem_addr}, 32'd1);
    chk("s2_we_lo", {31'd0, imem_we}, 32'd0);

    // Junk before sync is silently discarded.
    base = wr_cnt;
    pulse_start();
    chk("s3_done_clr", {31'd0, done}, 32'd0);
    chk("s3_cpu_off",  {31'd0, cpu_en}, 32'd0);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h22);
    send_byte(8'h11);
    send_byte(8'h32);
    chk("s3_done", {31'd0, done}, 32'd1);
    tick();
    chk("s3_nwr", wr_cnt - base, 32'd2);
    chk("s3_d0",  {16'd0, wr_data[base]}, 32'h0001);
    chk("s3_d1",  {16'd0, wr_data[base+1]}, 32'h1122);

    // Bad checksum.
    base = wr_cnt;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h22);
    send_byte(8'h11);
    send_byte(8'h33);
    chk("s4_err",    {30'd0, err}, 32'd2);
    chk("s4_done",   {31'd0, done}, 32'd0);
    chk("s4_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("s4_busy",   {31'd0, busy}, 32'd0);
    tick();
    chk("s4_nwr", wr_cnt - base, 32'd2);
    pulse_start();
    chk("s4_err_clr", {30'd0, err}, 32'd0);
    chk("s4_busy_again", {31'd0, busy}, 32'd1);

    // Zero length, reusing the load just started.
    base = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("s5_zero_err", {30'd0, err}, 32'd1);
    chk("s5_zero_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("s5_zero_nwr", wr_cnt - base, 32'd0);

    // 257 words exceeds a 256-word memory.
    base = wr_cnt;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    chk("s5_big_err", {30'd0, err}, 32'd1);
    chk("s5_big_done", {31'd0, done}, 32'd0);
    tick();
    chk("s5_big_nwr", wr_cnt - base, 32'd0);

    // Stall after the first payload byte: 16 idle cycles reach the limit, abort lands one cycle later.
    base = wr_cnt;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h77);
    repeat (16) tick();
    chk("s6_pre_busy", {31'd0, busy}, 32'd1);
    chk("s6_pre_err",  {30'd0, err}, 32'd0);
    chk("s6_pre_ready", {31'd0, rx_ready}, 32'd0);
    tick();
    chk("s6_to_err",  {30'd0, err}, 32'd3);
    chk("s6_to_busy", {31'd0, busy}, 32'd0);
    chk("s6_to_cpu",  {31'd0, cpu_en}, 32'd0);
    chk("s6_to_nwr",  wr_cnt - base, 32'd0);

    // Reset in the middle of the payload.
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h22);
    rst_n = 1'b0;
    tick();
    chk("s6_rst_busy",  {31'd0, busy}, 32'd0);
    chk("s6_rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("s6_rst_we",    {31'd0, imem_we}, 32'd0);
    chk("s6_rst_err",   {30'd0, err}, 32'd0);
    chk("s6_rst_addr",  {24'd0, imem_addr}, 32'd0);
    rst_n = 1'b1;
    tick();
    base = wr_cnt;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h26);
    chk("s6_post_done", {31'd0, done}, 32'd1);
    chk("s6_post_cpu",  {31'd0, cpu_en}, 32'd1);
    tick();
    chk("s6_post_nwr", wr_cnt - base, 32'd1);
    chk("s6_post_a0",  {24'd0, wr_addr[base]}, 32'd0);
    chk("s6_post_d0",  {16'd0, wr_data[base]}, 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
